// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S ADC deserialiser.
package audio_pkg;

    localparam int AUDIO_WORD_W = 32;
    localparam int AUDIO_CH_W   = 16;
    localparam int CNT_W        = 5;

    localparam logic LEFT_LRCK = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT
    } state_t;

endpackage

// File: rtl/audio_adc_deser_if.sv
// Codec serial inputs and the parallel stereo result of the deserialiser.
interface audio_adc_deser_if;

    logic                             AUD_BCLK;
    logic                             AUD_ADCLRCK;
    logic                             AUD_ADCDAT;
    logic [audio_pkg::AUDIO_WORD_W-1:0] audioIn;
    logic                             sample_valid;
    logic                             frame_err;

    modport master (
        output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
        input  audioIn, sample_valid, frame_err
    );

    modport slave (
        input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
        output audioIn, sample_valid, frame_err
    );

endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous input, with optional rise detect
// on the synchronised value.
module bit_sync #(
    parameter int STAGES   = 2,
    parameter bit RISE_DET = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    // NOTE: flops use <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

    generate
        if (RISE_DET) begin : g_rise
            logic prev_q;
            logic prev_d;

            always_comb prev_d = q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) prev_q <= 1'b0;
                else        prev_q <= prev_d;
            end

            assign rise = q & ~prev_q;
        end else begin : g_no_rise
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/audio_adc_deser.sv
// I2S ADC receiver: oversamples BCLK/LRCK/DAT in the clk domain and assembles
// MSB-aligned left+right words into one 32-bit stereo sample.
module audio_adc_deser
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    audio_adc_deser_if.slave aud
);

    logic bclk_rise;
    logic bclk_s_unused;
    logic lrck_s;
    logic dat_s;
    logic lrck_rise_unused;
    logic dat_rise_unused;

    bit_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b1)) u_sync_bclk (
        .clk(clk), .rst_n(rst), .d(aud.AUD_BCLK), .q(bclk_s_unused), .rise(bclk_rise)
    );
    bit_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_lrck (
        .clk(clk), .rst_n(rst), .d(aud.AUD_ADCLRCK), .q(lrck_s), .rise(lrck_rise_unused)
    );
    bit_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_dat (
        .clk(clk), .rst_n(rst), .d(aud.AUD_ADCDAT), .q(dat_s), .rise(dat_rise_unused)
    );

    state_t                  state_q, state_d;
    logic                    ch_q, ch_d;
    logic                    lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
    logic [AUDIO_CH_W-1:0]   shreg_q, shreg_d;
    logic [AUDIO_CH_W-1:0]   left_hold_q, left_hold_d;
    logic                    left_ok_q, left_ok_d;
    logic [AUDIO_WORD_W-1:0] audio_q, audio_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;

    logic [AUDIO_CH_W-1:0]   shreg_next;
    logic [AUDIO_CH_W-1:0]   word_aligned;
    logic                    lr_edge;

    assign shreg_next   = {shreg_q[AUDIO_CH_W-2:0], dat_s};
    // shreg starts cleared per channel, so only the low SAMPLE_BITS are populated.
    assign word_aligned = shreg_next << (AUDIO_CH_W - SAMPLE_BITS);
    assign lr_edge      = lrck_s ^ lr_prev_q;

    // NOTE: every signal gets its hold/default value first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        lr_prev_d   = lr_prev_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        audio_d     = audio_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;

        if (bclk_rise) begin
            lr_prev_d = lrck_s;
            // An edge rise is the I2S delay slot and never carries a data bit.
            if (lr_edge) begin
                if (state_q == SHIFT) begin
                    ferr_d    = 1'b1;
                    left_ok_d = 1'b0;
                end
                ch_d     = lrck_s;
                bitcnt_d = '0;
                shreg_d  = '0;
                state_d  = SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_d  = shreg_next;
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(SAMPLE_BITS - 1)) begin
                    state_d = WAIT;
                    if (ch_q == LEFT_LRCK) begin
                        left_hold_d = word_aligned;
                        left_ok_d   = 1'b1;
                    end else if (left_ok_q) begin
                        audio_d   = {left_hold_q, word_aligned};
                        valid_d   = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: left_hold and shreg are plain registers, so they are reset with the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ch_q        <= LEFT_LRCK;
            lr_prev_q   <= 1'b0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            audio_q     <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            lr_prev_q   <= lr_prev_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            audio_q     <= audio_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    assign aud.audioIn      = audio_q;
    assign aud.sample_valid = valid_q;
    assign aud.frame_err    = ferr_q;

endmodule

// File: tb/tb_audio_adc_deser.sv
// Directed bench for audio_adc_deser: a 16-bit and a 12-bit instance share one
// generated I2S stream; each task checks one scenario against hand-computed values.
module tb_audio_adc_deser;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic bclk = 1'b0;
    logic lrck = 1'b0;
    logic dat  = 1'b0;

    int errors = 0;
    int checks = 0;

    int cyc     = 0;
    int lsb_cyc = 0;

    int a_valid_cnt = 0;
    int a_ferr_cnt  = 0;
    int a_width_err = 0;
    int a_lat       = -1;
    int b_valid_cnt = 0;
    logic a_valid_prev = 1'b0;
    logic a_ferr_prev  = 1'b0;

    audio_adc_deser_if bus_a ();
    audio_adc_deser_if bus_b ();

    assign bus_a.AUD_BCLK    = bclk;
    assign bus_a.AUD_ADCLRCK = lrck;
    assign bus_a.AUD_ADCDAT  = dat;
    assign bus_b.AUD_BCLK    = bclk;
    assign bus_b.AUD_ADCLRCK = lrck;
    assign bus_b.AUD_ADCDAT  = dat;

    audio_adc_deser #(.SAMPLE_BITS(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .aud(bus_a)
    );

    audio_adc_deser #(.SAMPLE_BITS(12), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .aud(bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus_a.sample_valid) begin
            a_valid_cnt++;
            a_lat = cyc - lsb_cyc;
        end
        if (bus_a.frame_err) a_ferr_cnt++;
        if ((bus_a.sample_valid && a_valid_prev) || (bus_a.frame_err && a_ferr_prev))
            a_width_err++;
        a_valid_prev = bus_a.sample_valid;
        a_ferr_prev  = bus_a.frame_err;
        if (bus_b.sample_valid) b_valid_cnt++;
    end

    // Half a BCLK period is 4 clk cycles; edges land 2 ns after a falling clk edge.
    task automatic half();
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic clear_counts();
        a_valid_cnt = 0;
        a_ferr_cnt  = 0;
        a_width_err = 0;
        b_valid_cnt = 0;
        a_lat       = -1;
    endtask

    // One LRCK slot: period 0 is the delay bit, periods 1..nbits carry MSB..LSB,
    // the rest carry pad. rst_rel>0 holds reset low from period 0 until period rst_rel.
    task automatic send_slot(input logic lr, input logic [15:0] word, input int nbits,
                             input int total, input logic pad, input int rst_rel);
        for (int k = 0; k < total; k++) begin
            bclk = 1'b0;
            if (k == 0) lrck = lr;
            if (k >= 1 && k <= nbits) dat = word[nbits-k];
            else                      dat = pad;
            if (rst_rel > 0 && k == 0)       rst = 1'b0;
            if (rst_rel > 0 && k == rst_rel) rst = 1'b1;
            half();
            bclk = 1'b1;
            if (k == nbits) lsb_cyc = cyc;
            half();
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits,
                              input int total, input logic pad);
        send_slot(1'b0, l, nbits, total, pad, 0);
        send_slot(1'b1, r, nbits, total, pad, 0);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.audioIn !== 32'h0) begin
            errors++; $display("FAIL reset_audio: got %h expected %h", bus_a.audioIn, 32'h0);
        end
        checks++;
        if (bus_a.sample_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", bus_a.sample_valid);
        end
        checks++;
        if (bus_a.frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_ferr: got %b expected 0", bus_a.frame_err);
        end
        checks++;
        if (bus_b.audioIn !== 32'h0) begin
            errors++; $display("FAIL reset_audio_b: got %h expected %h", bus_b.audioIn, 32'h0);
        end
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic test_basic();
        send_slot(1'b1, 16'h0000, 16, 17, 1'b0, 0);
        clear_counts();
        send_frame(16'h8001, 16'h7FFE, 16, 17, 1'b0);
        settle();
        checks++;
        if (a_valid_cnt !== 1) begin
            errors++; $display("FAIL basic_pulses: got %0d expected 1", a_valid_cnt);
        end
        checks++;
        if (bus_a.audioIn !== 32'h80017FFE) begin
            errors++; $display("FAIL basic_audio: got %h expected %h", bus_a.audioIn, 32'h80017FFE);
        end
        checks++;
        if (a_lat < 2 || a_lat > 4) begin
            errors++; $display("FAIL basic_latency: got %0d clk expected 2..4", a_lat);
        end
        checks++;
        if (a_ferr_cnt !== 0) begin
            errors++; $display("FAIL basic_ferr: got %0d expected 0", a_ferr_cnt);
        end
        checks++;
        if (a_width_err !== 0) begin
            errors++; $display("FAIL basic_width: got %0d wide pulses expected 0", a_width_err);
        end
    endtask

    task automatic test_padded();
        clear_counts();
        send_frame(16'h1234, 16'hFEDC, 16, 32, 1'b1);
        settle();
        checks++;
        if (a_valid_cnt !== 1) begin
            errors++; $display("FAIL padded_pulses: got %0d expected 1", a_valid_cnt);
        end
        checks++;
        if (bus_a.audioIn !== 32'h1234FEDC) begin
            errors++; $display("FAIL padded_audio: got %h expected %h", bus_a.audioIn, 32'h1234FEDC);
        end
        checks++;
        if (a_ferr_cnt !== 0) begin
            errors++; $display("FAIL padded_ferr: got %0d expected 0", a_ferr_cnt);
        end
    endtask

    task automatic test_short_frame();
        clear_counts();
        send_slot(1'b0, 16'h02AA, 10, 11, 1'b0, 0);
        send_slot(1'b1, 16'h5555, 16, 17, 1'b0, 0);
        settle();
        checks++;
        if (a_ferr_cnt !== 1) begin
            errors++; $display("FAIL short_ferr: got %0d expected 1", a_ferr_cnt);
        end
        checks++;
        if (a_valid_cnt !== 0) begin
            errors++; $display("FAIL short_no_valid: got %0d expected 0", a_valid_cnt);
        end
        checks++;
        if (bus_a.audioIn !== 32'h1234FEDC) begin
            errors++; $display("FAIL short_hold: got %h expected %h", bus_a.audioIn, 32'h1234FEDC);
        end
        clear_counts();
        send_frame(16'h0F0F, 16'hF0F0, 16, 17, 1'b0);
        settle();
        checks++;
        if (a_valid_cnt !== 1) begin
            errors++; $display("FAIL short_next_pulses: got %0d expected 1", a_valid_cnt);
        end
        checks++;
        if (bus_a.audioIn !== 32'h0F0FF0F0) begin
            errors++; $display("FAIL short_next_audio: got %h expected %h", bus_a.audioIn, 32'h0F0FF0F0);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_slot(1'b0, 16'hAAAA, 16, 17, 1'b0, 0);
        clear_counts();
        send_slot(1'b1, 16'h5555, 16, 17, 1'b0, 6);
        settle();
        checks++;
        if (a_valid_cnt !== 0) begin
            errors++; $display("FAIL midrst_no_valid: got %0d expected 0", a_valid_cnt);
        end
        checks++;
        if (bus_a.audioIn !== 32'h0) begin
            errors++; $display("FAIL midrst_audio: got %h expected %h", bus_a.audioIn, 32'h0);
        end
        send_slot(1'b0, 16'h5A5A, 16, 17, 1'b0, 0);
        settle();
        checks++;
        if (a_valid_cnt !== 0 || bus_a.audioIn !== 32'h0) begin
            errors++;
            $display("FAIL midrst_left_only: got %0d pulses audio %h expected 0 pulses audio 0",
                     a_valid_cnt, bus_a.audioIn);
        end
        send_slot(1'b1, 16'hC3C3, 16, 17, 1'b0, 0);
        settle();
        checks++;
        if (a_valid_cnt !== 1) begin
            errors++; $display("FAIL midrst_pulses: got %0d expected 1", a_valid_cnt);
        end
        checks++;
        if (bus_a.audioIn !== 32'h5A5AC3C3) begin
            errors++; $display("FAIL midrst_audio_final: got %h expected %h", bus_a.audioIn, 32'h5A5AC3C3);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) begin
            bclk = 1'b0;
            if (k == 0) lrck = 1'b0;
            dat = k[0];
            half();
            bclk = 1'b1;
            half();
        end
        bclk = 1'b0;
        checks++;
        if (bus_a.audioIn !== 32'h5A5AC3C3) begin
            errors++; $display("FAIL async_pre_audio: got %h expected %h", bus_a.audioIn, 32'h5A5AC3C3);
        end
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (bus_a.audioIn !== 32'h0) begin
            errors++; $display("FAIL async_audio: got %h expected %h", bus_a.audioIn, 32'h0);
        end
        checks++;
        if (bus_a.sample_valid !== 1'b0) begin
            errors++; $display("FAIL async_valid: got %b expected 0", bus_a.sample_valid);
        end
        checks++;
        if (bus_a.frame_err !== 1'b0) begin
            errors++; $display("FAIL async_ferr: got %b expected 0", bus_a.frame_err);
        end
        for (int i = 0; i < 10; i++) begin
            if (i % 4 == 0) bclk = ~bclk;
            dat = ~dat;
            @(negedge clk);
            checks++;
            if (bus_a.audioIn !== 32'h0 || bus_a.sample_valid !== 1'b0 || bus_a.frame_err !== 1'b0) begin
                errors++;
                $display("FAIL async_hold_%0d: got audio %h valid %b ferr %b expected all 0",
                         i, bus_a.audioIn, bus_a.sample_valid, bus_a.frame_err);
            end
        end
        bclk = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic test_reduced_width();
        send_slot(1'b1, 16'h0000, 12, 13, 1'b0, 0);
        clear_counts();
        send_frame(16'h0ABC, 16'h0123, 12, 13, 1'b0);
        settle();
        checks++;
        if (b_valid_cnt !== 1) begin
            errors++; $display("FAIL width12_pulses: got %0d expected 1", b_valid_cnt);
        end
        checks++;
        if (bus_b.audioIn !== 32'hABC01230) begin
            errors++; $display("FAIL width12_audio: got %h expected %h", bus_b.audioIn, 32'hABC01230);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_padded();
        test_short_frame();
        test_reset_mid_frame();
        test_async_reset();
        test_reduced_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_adc_deser.md
# audio_adc_deser

Receives the codec's serial ADC stream (I2S format) and produces the parallel stereo word `audioIn` consumed by the moving-average filter stage. It runs entirely in the system `clk` domain: `AUD_BCLK`, `AUD_ADCLRCK` and `AUD_ADCDAT` are oversampled through synchronisers, never used as clocks. One `sample_valid` pulse marks each completed left+right pair, and short frames are flagged.

## Interface
- `SAMPLE_BITS`, 16: bits captured per channel. Legal range is 8..16.
- `SYNC_STAGES`, 2: synchroniser depth on each audio input. Legal values are 2 or more.
- `clk` in 1: system clock. Must be at least 4× the `AUD_BCLK` frequency.
- `rst` in 1: reset, asynchronous, active-low.
- `AUD_BCLK` in 1: codec bit clock, asynchronous to `clk`.
- `AUD_ADCLRCK` in 1: codec ADC frame clock. Low = left channel, high = right channel.
- `AUD_ADCDAT` in 1: codec serial ADC data, MSB first.
- `audioIn` out 32: `{left[15:0], right[15:0]}` in two's complement.
- `sample_valid` out 1: one-`clk` pulse when `audioIn` updates.
- `frame_err` out 1: one-`clk` pulse when a short channel is discarded.

## Operation
- **Input conditioning:** each input passes through a `SYNC_STAGES` flop chain. `bclk_rise` = synced BCLK high and previous synced BCLK low. All state advances only on cycles where `bclk_rise` is true.
- **Edge detection:** on each `bclk_rise`, synced LRCK is compared with the registered `lr_prev`. A difference is an LRCK edge; `lr_prev` then updates.
- **I2S one-bit delay:** the BCLK rise that exposes an LRCK edge carries no data for the new channel. The following `SAMPLE_BITS` rises carry MSB..LSB.
- **State machine:**
  - `IDLE` (reset state): ignore data. An LRCK edge sets `ch` = new LRCK value, clears `bitcnt`, and moves to `SHIFT`.
  - `SHIFT`: each non-edge rise shifts the data bit into `shreg` and increments `bitcnt`.
    - When `bitcnt` reaches `SAMPLE_BITS`, the word completes and the state moves to `WAIT`.
    - An LRCK edge before completion pulses `frame_err`, discards `shreg`, clears `left_ok`, and restarts `SHIFT` for the new channel.
  - `WAIT`: extra bits are ignored; the codec may send up to 32 BCLKs per channel. An LRCK edge restarts `SHIFT`.
- **Word completion:**
  - `ch` = left: store the word in `left_hold` and set `left_ok`.
  - `ch` = right with `left_ok` = 1: `audioIn` ← `{left_hold, right_word}`, `sample_valid` = 1, clear `left_ok`.
  - `ch` = right with `left_ok` = 0: drop the word. No pulse.
- **Width rule:** a channel word is MSB-aligned into 16 bits; unused LSBs are 0. For example, with `SAMPLE_BITS` = 12 the channel field is `{word[11:0], 4'b0}`.
- **Simultaneous events:** an LRCK edge on the same rise as a would-be data bit is always treated as the delay bit and never shifted in.

## Timing
- **Reset:** `rst` low clears all registers immediately, with no `clk` edge needed.
  - `audioIn` = 0, `sample_valid` = 0, `frame_err` = 0.
  - State = `IDLE`, `left_ok` = 0, `lr_prev` = 0.
  - The synchroniser chains also clear to 0.
- **Latency:** `audioIn` and `sample_valid` update on the `clk` edge where the right LSB's `bclk_rise` is seen. That is `SYNC_STAGES`+1 `clk` edges after the raw BCLK rise, with ±1 `clk` of synchroniser uncertainty.
- **Pulse widths:** `sample_valid` and `frame_err` are exactly one `clk` wide and are deasserted on all other cycles.
- **Output hold:** `audioIn` holds its value between pulses.
- **Reset mid-frame:** the block returns to `IDLE` and discards any partial data. The first `sample_valid` after reset requires a complete left channel followed by a complete right channel.

## Structure
- **Shared package `audio_pkg`:**
  - state enum: `IDLE`, `SHIFT`, `WAIT`
  - `AUDIO_WORD_W` = 32, `AUDIO_CH_W` = 16
  - `LEFT_LRCK` = 1'b0
- **Sub-module `bit_sync`:** a parameterised `SYNC_STAGES` synchroniser with async active-low reset and an optional rise-detect output. It is instantiated three times: BCLK with rise detect, LRCK, and DAT.
- **Top level:** the FSM, `bitcnt`, `shreg`, `left_hold` and the output registers stay in `audio_adc_deser`.

## Test plan
1. **Basic frame:** reset, then an I2S frame with 16 BCLK/channel, left = 16'h8001, right = 16'h7FFE. Expect `audioIn` = 32'h80017FFE with a single `sample_valid` pulse, 3±1 `clk` after the right-LSB BCLK rise.
2. **Padded channels:** 32 BCLK/channel, left = 16'h1234, right = 16'hFEDC, trailing bits all 1. Expect `audioIn` = 32'h1234FEDC; the trailing ones are ignored.
3. **Short frame:** LRCK toggles after 10 left bits. Expect one `frame_err` pulse and no `sample_valid` for that frame. The next full frame (left = 16'h0F0F, right = 16'hF0F0) gives 32'h0F0FF0F0.
4. **Reset released mid-frame:** release `rst` mid-right-channel. Expect no `sample_valid` and `audioIn` = 0 until a full left and right are received; then exactly one pulse with the correct value.
5. **Async reset mid-shift:** assert `rst` between `clk` edges during `SHIFT`. Expect `audioIn` = 0 and both pulse outputs 0 immediately, and they stay 0 while `rst` is low.
6. **Reduced width:** `SAMPLE_BITS` = 12, left = 12'hABC, right = 12'h123. Expect `audioIn` = 32'hABC01230.
